// File: rtl/read_xbar_rr.sv
// Read crossbar: per-bank round-robin arbitration of read agents onto BRAM banks with a
// fixed-latency return path. Optional per-bank conflict counters: READ_XBAR_CONFLICT_CNT_EN.
module read_xbar_rr #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NB_BANK      = 2,
  parameter int unsigned NB_RDAGENT   = 2,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned SELECT_WIDTH = (NB_BANK == 1) ? 1 : $clog2(NB_BANK),
  parameter int unsigned AGENT_WIDTH  = (NB_RDAGENT == 1) ? 1 : $clog2(NB_RDAGENT)
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [NB_RDAGENT-1:0]              m_rden,
  output logic [NB_RDAGENT-1:0]              m_rdready,
  input  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   m_rdaddr,
  input  logic [NB_RDAGENT*SELECT_WIDTH-1:0] rdselect,
  output logic [NB_RDAGENT-1:0]              m_rdvalid,
  output logic [NB_RDAGENT*DATA_WIDTH-1:0]   m_rddata,
  output logic [NB_BANK-1:0]                 s_rden,
  output logic [NB_BANK*ADDR_WIDTH-1:0]      s_rdaddr,
  input  logic [NB_BANK*DATA_WIDTH-1:0]      s_rddata
`ifdef READ_XBAR_CONFLICT_CNT_EN
  ,
  output logic [NB_BANK*16-1:0]              conflict_cnt
`endif
);

  localparam int unsigned LAST_AGENT = NB_RDAGENT - 1;

  logic [NB_RDAGENT-1:0]  req       [NB_BANK];
  logic [AGENT_WIDTH-1:0] ptr_q     [NB_BANK];
  logic [AGENT_WIDTH-1:0] ptr_d     [NB_BANK];
  logic [NB_BANK-1:0]     grant_vld;
  logic [AGENT_WIDTH-1:0] grant_idx [NB_BANK];
  logic [RD_LATENCY-1:0]  pv_q      [NB_BANK];
  logic [RD_LATENCY-1:0]  pv_d      [NB_BANK];
  logic [AGENT_WIDTH-1:0] pa_q      [NB_BANK][RD_LATENCY];
  logic [AGENT_WIDTH-1:0] pa_d      [NB_BANK][RD_LATENCY];

  // Request matrix; an out-of-range selector matches no bank and is never granted
  always_comb begin
    for (int b = 0; b < NB_BANK; b++) begin
      req[b] = '0;
      for (int i = 0; i < NB_RDAGENT; i++) begin
        req[b][i] = !areset && m_rden[i] &&
                    (rdselect[i*SELECT_WIDTH +: SELECT_WIDTH] == SELECT_WIDTH'(b));
      end
    end
  end

  // Per-bank round-robin: search starts just after the last winner
  always_comb begin
    int   cand;
    logic found;
    logic [AGENT_WIDTH-1:0] win;
    cand      = 0;
    found     = 1'b0;
    win       = '0;
    m_rdready = '0;
    s_rden    = '0;
    s_rdaddr  = '0;
    grant_vld = '0;
    for (int b = 0; b < NB_BANK; b++) begin
      ptr_d[b]     = ptr_q[b];
      grant_idx[b] = '0;
      found        = 1'b0;
      win          = '0;
      for (int k = 1; k <= NB_RDAGENT; k++) begin
        cand = (int'(ptr_q[b]) + k) % NB_RDAGENT;
        if (!found && req[b][cand]) begin
          found = 1'b1;
          win   = AGENT_WIDTH'(cand);
        end
      end
      grant_vld[b] = found;
      grant_idx[b] = win;
      if (found) begin
        ptr_d[b]       = win;
        s_rden[b]      = 1'b1;
        m_rdready[win] = 1'b1;
        s_rdaddr[b*ADDR_WIDTH +: ADDR_WIDTH] = m_rdaddr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Return pipeline: {valid, agent} shifts in lock-step with the bank latency
  always_comb begin
    for (int b = 0; b < NB_BANK; b++) begin
      pv_d[b]    = '0;
      pv_d[b][0] = grant_vld[b];
      pa_d[b][0] = grant_idx[b];
      for (int s = 1; s < RD_LATENCY; s++) begin
        pv_d[b][s] = pv_q[b][s-1];
        pa_d[b][s] = pa_q[b][s-1];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int b = 0; b < NB_BANK; b++) begin
        ptr_q[b] <= AGENT_WIDTH'(LAST_AGENT);
        pv_q[b]  <= '0;
        for (int s = 0; s < RD_LATENCY; s++) pa_q[b][s] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      pv_q  <= pv_d;
      pa_q  <= pa_d;
    end
  end

  // Steer each bank's tail data to its agent; an agent owns at most one tail per cycle
  always_comb begin
    int a;
    a         = 0;
    m_rdvalid = '0;
    m_rddata  = '0;
    for (int b = 0; b < NB_BANK; b++) begin
      if (!areset && pv_q[b][RD_LATENCY-1]) begin
        a            = int'(pa_q[b][RD_LATENCY-1]);
        m_rdvalid[a] = 1'b1;
        m_rddata[a*DATA_WIDTH +: DATA_WIDTH] = s_rddata[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef READ_XBAR_CONFLICT_CNT_EN
  logic [15:0] cnt_q [NB_BANK];
  logic [15:0] cnt_d [NB_BANK];

  // Saturating count of cycles with two or more requesters on a bank
  always_comb begin
    conflict_cnt = '0;
    for (int b = 0; b < NB_BANK; b++) begin
      cnt_d[b] = cnt_q[b];
      if (($countones(req[b]) >= 2) && (cnt_q[b] != 16'hFFFF)) cnt_d[b] = cnt_q[b] + 16'd1;
      conflict_cnt[b*16 +: 16] = cnt_q[b];
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int b = 0; b < NB_BANK; b++) cnt_q[b] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_read_xbar_rr.sv
// Bench for read_xbar_rr: 3 agents, 3 banks (selector 3 is out of range), latency 3.
// Build with READ_XBAR_CONFLICT_CNT_EN to also exercise the conflict counters.
module tb_read_xbar_rr;
  localparam int unsigned AW = 8, DW = 32, NB = 3, NA = 3, LAT = 3, SW = 2;

  logic aclk = 1'b0;
  logic areset;
  logic [NA-1:0]    m_rden, m_rdready, m_rdvalid;
  logic [NA*AW-1:0] m_rdaddr;
  logic [NA*SW-1:0] rdselect;
  logic [NA*DW-1:0] m_rddata;
  logic [NB-1:0]    s_rden;
  logic [NB*AW-1:0] s_rdaddr;
  logic [NB*DW-1:0] s_rddata;
`ifdef READ_XBAR_CONFLICT_CNT_EN
  logic [NB*16-1:0] conflict_cnt;
`endif

  logic [NA-1:0] req;
  logic [AW-1:0] addr [NA];
  logic [SW-1:0] sel  [NA];

  int n_cmp = 0, n_bad = 0, cyc = 0;

  always #5 aclk = ~aclk;

  read_xbar_rr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_BANK(NB), .NB_RDAGENT(NA),
                 .RD_LATENCY(LAT)) dut (
    .aclk(aclk), .areset(areset), .m_rden(m_rden), .m_rdready(m_rdready),
    .m_rdaddr(m_rdaddr), .rdselect(rdselect), .m_rdvalid(m_rdvalid), .m_rddata(m_rddata),
    .s_rden(s_rden), .s_rdaddr(s_rdaddr), .s_rddata(s_rddata)
`ifdef READ_XBAR_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always_comb begin
    m_rden = req;
    for (int i = 0; i < NA; i++) begin
      m_rdaddr[i*AW +: AW] = addr[i];
      rdselect[i*SW +: SW] = sel[i];
    end
  end

  function automatic logic [DW-1:0] bank_word(int b, logic [AW-1:0] a);
    return {8'hA0 + 8'(b), 16'h5A5A, a};
  endfunction

  // Bank array model: returns bank_word LAT cycles after s_rden, junk otherwise
  logic [NB-1:0]         bv [LAT] = '{default: '0};
  logic [NB-1:0][AW-1:0] ba [LAT];
  logic [DW-1:0]         junk [NB];
  always @(posedge aclk) begin
    bv[0] <= s_rden;
    ba[0] <= s_rdaddr;
    for (int s = 1; s < LAT; s++) begin
      bv[s] <= bv[s-1];
      ba[s] <= ba[s-1];
    end
    for (int b = 0; b < NB; b++) junk[b] <= $urandom;
  end
  always_comb begin
    for (int b = 0; b < NB; b++)
      s_rddata[b*DW +: DW] = bv[LAT-1][b] ? bank_word(b, ba[LAT-1][b]) : junk[b];
  end

  // Reference model: last winner per bank plus a list of pending returns
  typedef struct { int due; int agent; logic [DW-1:0] data; } ret_t;
  ret_t pend[$];
  int last [NB] = '{default: NA-1};
  int ccnt [NB] = '{default: 0};
  int e_win [NB];
  logic [NA-1:0]    e_ready, e_rvalid, granted;
  logic [NB-1:0]    e_rden;
  logic [NB*AW-1:0] e_addr;
  logic [NA*DW-1:0] e_rdata;

  function automatic void compute_expect();
    int a;
    e_ready = '0; e_rden = '0; e_addr = '0; e_rvalid = '0; e_rdata = '0;
    for (int b = 0; b < NB; b++) begin
      e_win[b] = -1;
      if (!areset)
        for (int k = 1; k <= NA; k++) begin
          a = (last[b] + k) % NA;
          if (e_win[b] < 0 && req[a] && int'(sel[a]) == b) e_win[b] = a;
        end
      if (e_win[b] >= 0) begin
        e_rden[b] = 1'b1;
        e_ready[e_win[b]] = 1'b1;
        e_addr[b*AW +: AW] = addr[e_win[b]];
      end
    end
    if (!areset)
      foreach (pend[j])
        if (pend[j].due == cyc) begin
          e_rvalid[pend[j].agent] = 1'b1;
          e_rdata[pend[j].agent*DW +: DW] = pend[j].data;
        end
  endfunction

  task automatic advance();
    int n;
    compute_expect();
    granted = e_ready;
    if (areset) begin
      pend.delete();
      for (int b = 0; b < NB; b++) begin last[b] = NA - 1; ccnt[b] = 0; end
    end else begin
      while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
      for (int b = 0; b < NB; b++) begin
        n = 0;
        for (int i = 0; i < NA; i++) if (req[i] && int'(sel[i]) == b) n++;
        if (n >= 2 && ccnt[b] < 65535) ccnt[b]++;
        if (e_win[b] >= 0) begin
          pend.push_back('{cyc + LAT, e_win[b], bank_word(b, addr[e_win[b]])});
          last[b] = e_win[b];
        end
      end
    end
    @(posedge aclk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    areset = 1'b1; req = '0;
    #4; advance();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1; req = '1;
    for (int i = 0; i < NA; i++) begin addr[i] = AW'($urandom); sel[i] = SW'(i); end
    for (int c = 0; c < 3; c++) begin
      #4;
      n_cmp++;
      if (m_rdready !== '0 || s_rden !== '0 || m_rdvalid !== '0) begin
        n_bad++;
        $display("FAIL reset_ctl c%0d: ready=%b rden=%b rvalid=%b, required all 0",
                 c, m_rdready, s_rden, m_rdvalid);
      end
      n_cmp++;
      if (m_rddata !== '0 || s_rdaddr !== '0) begin
        n_bad++;
        $display("FAIL reset_data c%0d: rddata=%h s_rdaddr=%h, required 0", c, m_rddata, s_rdaddr);
      end
      advance();
    end
    areset = 1'b0; req = '0;
  endtask

  task automatic test_no_conflict();
    do_reset();
    req = 3'b011;
    addr[0] = 8'h10; sel[0] = 2'd0;
    addr[1] = 8'h20; sel[1] = 2'd1;
    #4;
    n_cmp++;
    if (m_rdready !== 3'b011 || s_rden !== 3'b011) begin
      n_bad++;
      $display("FAIL nc_grant: ready=%b rden=%b, required 011/011", m_rdready, s_rden);
    end
    n_cmp++;
    if (s_rdaddr[15:0] !== 16'h2010) begin
      n_bad++;
      $display("FAIL nc_addr: s_rdaddr=%h, required 2010", s_rdaddr[15:0]);
    end
    advance();
    req = '0;
    for (int c = 1; c <= LAT; c++) begin
      #4;
      n_cmp++;
      if (m_rdvalid !== ((c == LAT) ? 3'b011 : 3'b000)) begin
        n_bad++;
        $display("FAIL nc_rvalid T+%0d: got %b", c, m_rdvalid);
      end
      if (c == LAT) begin
        n_cmp++;
        if (m_rddata[31:0] !== 32'hA05A5A10 || m_rddata[63:32] !== 32'hA15A5A20 ||
            m_rddata[95:64] !== 32'h0) begin
          n_bad++;
          $display("FAIL nc_data: got %h, required 00000000_a15a5a20_a05a5a10", m_rddata);
        end
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req = '1;
    for (int i = 0; i < NA; i++) begin addr[i] = AW'($urandom); sel[i] = 2'd0; end
    for (int c = 0; c < 9 + LAT; c++) begin
      if (c == 9) req = '0;
      #4; compute_expect();
      if (c < 9) begin
        n_cmp++;
        if (m_rdready !== NA'(1 << (c % 3)) || s_rdaddr[7:0] !== addr[c % 3]) begin
          n_bad++;
          $display("FAIL rr_order c%0d: ready=%b addr=%h, required %b/%h",
                   c, m_rdready, s_rdaddr[7:0], NA'(1 << (c % 3)), addr[c % 3]);
        end
      end
      n_cmp++;
      if (m_rdvalid !== e_rvalid || m_rddata !== e_rdata) begin
        n_bad++;
        $display("FAIL rr_return c%0d: rvalid=%b data=%h, required %b/%h",
                 c, m_rdvalid, m_rddata, e_rvalid, e_rdata);
      end
      advance();
      for (int i = 0; i < NA; i++) if (granted[i]) addr[i] = AW'($urandom);
    end
  endtask

  task automatic test_stall();
    logic [NA-1:0] exp_rdy [3];
    logic [AW-1:0] exp_adr [3];
    exp_rdy = '{3'b100, 3'b001, 3'b010};
    exp_adr = '{8'h02, 8'h01, 8'h33};
    do_reset();
    req = 3'b010; addr[1] = 8'h11; sel[1] = 2'd0;
    #4; advance();
    req = 3'b111;
    addr[0] = 8'h01; sel[0] = 2'd0;
    addr[1] = 8'h33;
    addr[2] = 8'h02; sel[2] = 2'd0;
    for (int c = 0; c < 3; c++) begin
      #4;
      n_cmp++;
      if (m_rdready !== exp_rdy[c] || s_rdaddr[7:0] !== exp_adr[c]) begin
        n_bad++;
        $display("FAIL stall c%0d: ready=%b addr=%h, required %b/%h",
                 c, m_rdready, s_rdaddr[7:0], exp_rdy[c], exp_adr[c]);
      end
      advance();
      req = req & ~granted;
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    req = 3'b011;
    addr[0] = 8'h77; sel[0] = 2'd3;
    addr[1] = 8'h55; sel[1] = 2'd1;
    for (int c = 0; c < 4; c++) begin
      #4;
      n_cmp++;
      if (m_rdready !== 3'b010 || s_rden !== 3'b010) begin
        n_bad++;
        $display("FAIL oor c%0d: ready=%b rden=%b, required 010/010", c, m_rdready, s_rden);
      end
      advance();
    end
    req = '0;
  endtask

  task automatic test_reset_in_flight();
    do_reset();
    req = 3'b100; addr[2] = 8'h44; sel[2] = 2'd2;
    #4;
    n_cmp++;
    if (m_rdready !== 3'b100 || s_rden !== 3'b100) begin
      n_bad++;
      $display("FAIL rif_grant: ready=%b rden=%b, required 100/100", m_rdready, s_rden);
    end
    advance();
    req = '0; areset = 1'b1;
    #4; advance();
    areset = 1'b0;
    for (int c = 2; c <= LAT + 2; c++) begin
      #4;
      n_cmp++;
      if (m_rdvalid !== '0 || m_rddata !== '0) begin
        n_bad++;
        $display("FAIL rif_drop T+%0d: rvalid=%b data=%h, required 0", c, m_rdvalid, m_rddata);
      end
      advance();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < NA; i++) begin
      req[i] = 1'b0; addr[i] = AW'($urandom); sel[i] = SW'($urandom_range(0, NB - 1));
    end
    for (int c = 0; c < 400; c++) begin
      areset = ($urandom_range(0, 59) == 0);
      #4; compute_expect();
      n_cmp++;
      if (m_rdready !== e_ready || s_rden !== e_rden) begin
        n_bad++;
        $display("FAIL rnd_grant c%0d: ready=%b rden=%b, required %b/%b",
                 c, m_rdready, s_rden, e_ready, e_rden);
      end
      n_cmp++;
      if (s_rdaddr !== e_addr) begin
        n_bad++;
        $display("FAIL rnd_addr c%0d: got %h, required %h", c, s_rdaddr, e_addr);
      end
      n_cmp++;
      if (m_rdvalid !== e_rvalid || m_rddata !== e_rdata) begin
        n_bad++;
        $display("FAIL rnd_return c%0d: rvalid=%b data=%h, required %b/%h",
                 c, m_rdvalid, m_rddata, e_rvalid, e_rdata);
      end
      advance();
      for (int i = 0; i < NA; i++)
        if (granted[i] || !req[i]) begin
          req[i]  = 1'($urandom_range(0, 1));
          addr[i] = AW'($urandom);
          sel[i]  = SW'($urandom_range(0, NB - 1));
        end
    end
    areset = 1'b0; req = '0;
  endtask

`ifdef READ_XBAR_CONFLICT_CNT_EN
  task automatic test_conflict_cnt();
    do_reset();
    req = 3'b011;
    addr[0] = 8'h01; sel[0] = 2'd1;
    addr[1] = 8'h02; sel[1] = 2'd1;
    for (int c = 0; c < 5; c++) begin #4; advance(); end
    #4;
    n_cmp++;
    if (conflict_cnt[31:16] !== 16'd5 || conflict_cnt[15:0] !== 16'd0 ||
        conflict_cnt[47:32] !== 16'd0 || int'(conflict_cnt[31:16]) != ccnt[1]) begin
      n_bad++;
      $display("FAIL cnt_five: got %h, required 0000_0005_0000", conflict_cnt);
    end
    for (int c = 0; c < 65534; c++) begin #4; advance(); end
    #4;
    n_cmp++;
    if (conflict_cnt[31:16] !== 16'hFFFF || conflict_cnt[15:0] !== 16'd0) begin
      n_bad++;
      $display("FAIL cnt_sat: got %h, required 0000_ffff_0000", conflict_cnt);
    end
    advance();
    req = '0;
  endtask
`endif

  initial begin
    req = '0; areset = 1'b1;
    for (int i = 0; i < NA; i++) begin addr[i] = '0; sel[i] = '0; end
    test_reset();
    test_no_conflict();
    test_round_robin();
    test_stall();
    test_out_of_range();
    test_reset_in_flight();
    test_random();
`ifdef READ_XBAR_CONFLICT_CNT_EN
    test_conflict_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/read_xbar_rr.md
Name: read_xbar_rr

Overview:
- Parametrised successor of the bank read switch: routes NB_RDAGENT read agents onto NB_BANK BRAM banks through a full crossbar.
- Adds per-bank round-robin arbitration with a valid/ready handshake toward agents.
- Supports a configurable bank read latency and returns data to each agent with a read-valid strobe.
- Sits between the read agents and the bank array in the multi-port RAM top level.

Parameters:
ADDR_WIDTH, 8, read address width
DATA_WIDTH, 32, data width in bits
NB_BANK, 2, number of banks (one per write agent)
NB_RDAGENT, 2, number of read agents
RD_LATENCY, 1, bank read latency in cycles (s_rden to s_rddata valid), legal range 1..4
SELECT_WIDTH, NB_BANK==1 ? 1 : $clog2(NB_BANK), bank selector width
AGENT_WIDTH, NB_RDAGENT==1 ? 1 : $clog2(NB_RDAGENT), agent index width

Ports:
aclk  in  1  clock
areset  in  1  reset, synchronous, active-high
m_rden  in  NB_RDAGENT  per-agent read request (valid)
m_rdready  out  NB_RDAGENT  per-agent grant; transfer occurs when m_rden & m_rdready
m_rdaddr  in  NB_RDAGENT*ADDR_WIDTH  per-agent read address
rdselect  in  NB_RDAGENT*SELECT_WIDTH  per-agent target bank
m_rdvalid  out  NB_RDAGENT  read data valid strobe
m_rddata  out  NB_RDAGENT*DATA_WIDTH  read data
s_rden  out  NB_BANK  bank read enable
s_rdaddr  out  NB_BANK*ADDR_WIDTH  bank read address
s_rddata  in  NB_BANK*DATA_WIDTH  bank read data, valid RD_LATENCY cycles after s_rden

Behaviour:
- Single clock domain: aclk, reset areset (synchronous, active-high). All state is cleared on the aclk edge that samples areset=1.
- Reset values:
  - m_rdvalid=0 and m_rddata=0.
  - RR pointers = NB_RDAGENT-1, so agent 0 has highest priority first.
  - Return pipeline entries invalid.
- m_rdready, s_rden and s_rdaddr are combinational and remain 0 while areset=1.
- Request set per bank b: agents i with m_rden[i]=1 and rdselect[i]==b.
- Out-of-range rdselect (>=NB_BANK): request is never granted; m_rdready[i] stays 0.
- Arbitration, bank b, same cycle:
  - Search agents ptr[b]+1, ptr[b]+2, ... wrapping modulo NB_RDAGENT.
  - The first requester found wins: m_rdready[winner]=1, s_rden[b]=1, s_rdaddr[b]=m_rdaddr[winner].
  - ptr[b] <= winner on the next edge.
  - With no requester, ptr[b] holds and s_rden[b]=0; s_rdaddr[b] is don't-care and driven 0.
- Banks are independent, so up to min(NB_BANK,NB_RDAGENT) grants per cycle. An agent targets one bank per cycle, so it receives at most one grant.
- Agents must hold m_rden, m_rdaddr and rdselect stable until granted. A non-granted agent is stalled (back-pressure); no state change for it.
- Return path:
  - Per bank, a shift pipeline RD_LATENCY deep carries {valid, agent index}, loaded on grant.
  - When the tail entry of bank b is valid for agent a: m_rdvalid[a]=1 and m_rddata[a]=s_rddata[b], combinationally in the cycle s_rddata is valid.
  - Latency: data appears exactly RD_LATENCY cycles after the grant cycle.
  - At most one bank tail targets a given agent per cycle, because an agent gets at most one grant per cycle.
  - m_rddata[a]=0 whenever m_rdvalid[a]=0.
- Back-to-back: an agent may be granted every cycle; full throughput, no bubbles.
- Reset mid-operation: in-flight pipeline entries are discarded; no m_rdvalid is produced for reads issued before reset.
- NB_RDAGENT==1: arbitration degenerates to a direct pass; the pointer logic stays but is constant.

Optional Feature:
- Macro: READ_XBAR_CONFLICT_CNT_EN.
- Defined:
  - Extra output port conflict_cnt, NB_BANK*16 bits.
  - Per-bank counter increments by 1 in each cycle where bank b has >=2 requesters.
  - Counter saturates at 16'hFFFF; reset value 0.
- Undefined: the port and the counters are absent; behaviour otherwise identical.

Test Plan:
- Reset: hold areset=1 for 3 cycles with all m_rden=1 -> m_rdready=0, s_rden=0, m_rdvalid=0, m_rddata=0 throughout.
- No conflict, NB_RDAGENT=2, NB_BANK=2, RD_LATENCY=2:
  - Stimulus: agent0 reads bank0 at addr 0x10, agent1 reads bank1 at addr 0x20, same cycle T.
  - Response: both m_rdready=1 at T; s_rdaddr = {0x20,0x10}.
  - At T+2, bank model returns 0xA5A5_0010 / 0x5A5A_0020 -> m_rdvalid=2'b11 with matching data.
- Round-robin, NB_RDAGENT=3: all three agents continuously request bank0 -> grants in order 0,1,2,0,1,2; each agent's m_rdvalid arrives RD_LATENCY cycles after its grant.
- Stall and hold: agent1 waits 2 cycles on bank0 while agent0 is granted -> agent1 granted on the 3rd cycle after ptr passes; its address 0x33 appears on s_rdaddr[0] only in its grant cycle.
- Reset in flight, RD_LATENCY=3: grant at T, areset=1 at T+1 -> no m_rdvalid at T+3.
- Feature READ_XBAR_CONFLICT_CNT_EN: 5 cycles with 2 agents contending bank1 -> conflict_cnt[1]=5, conflict_cnt[0]=0. Preloading the count near 0xFFFF and running 4 more conflict cycles -> holds at 0xFFFF.
